// File: rtl/muldiv_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// muldiv_stall_ctrl_if
// Purpose : bundles the pipeline-side signals exchanged between the in-order
//           pipeline and the multiply/divide stall controller.
// Modports:
//   master - pipeline side: drives the ID/EX and IF/ID hazard information and
//            flush, and observes the pipeline-register enables, bubbles and
//            M-unit handshake produced by the controller.
//   slave  - controller side (muldiv_stall_ctrl): the reverse directions.
// Signals :
//   ID_EX_valid     EX stage holds a real instruction (not a bubble)
//   ID_EX_is_mul    EX instruction is MUL/MULH/MULHSU/MULHU
//   ID_EX_is_div    EX instruction is DIV/DIVU/REM/REMU
//   ID_EX_memread   EX instruction is a load
//   ID_EX_rd        EX destination register
//   IF_ID_rs1/rs2   ID source registers
//   IF_ID_uses_rs2  ID instruction reads rs2
//   flush           taken branch/jump kills IF, ID and EX
//   pc_write_en, IF_ID_write_en, ID_EX_write_en   register enables (0 holds)
//   ID_EX_bubble    load ID/EX with a NOP
//   EX_MEM_bubble   load EX/MEM with a NOP
//   md_start        one-cycle start pulse to the M unit
//   md_abort        one-cycle cancel pulse to the M unit
//   md_result_sel   EX/MEM captures the M-unit result this cycle
//   md_busy         M operation in progress
//   stall_count     saturating count of cycles with pc_write_en=0
// -----------------------------------------------------------------------------
interface muldiv_stall_ctrl_if;

  // Hazard information from the pipeline
  logic        ID_EX_valid;
  logic        ID_EX_is_mul;
  logic        ID_EX_is_div;
  logic        ID_EX_memread;
  logic [4:0]  ID_EX_rd;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic        IF_ID_uses_rs2;
  logic        flush;

  // Pipeline control from the controller
  logic        pc_write_en;
  logic        IF_ID_write_en;
  logic        ID_EX_write_en;
  logic        ID_EX_bubble;
  logic        EX_MEM_bubble;

  // M-unit handshake
  logic        md_start;
  logic        md_abort;
  logic        md_result_sel;
  logic        md_busy;

  // Statistics
  logic [31:0] stall_count;

  modport master (
    output ID_EX_valid, ID_EX_is_mul, ID_EX_is_div, ID_EX_memread, ID_EX_rd,
           IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2, flush,
    input  pc_write_en, IF_ID_write_en, ID_EX_write_en, ID_EX_bubble,
           EX_MEM_bubble, md_start, md_abort, md_result_sel, md_busy,
           stall_count
  );

  modport slave (
    input  ID_EX_valid, ID_EX_is_mul, ID_EX_is_div, ID_EX_memread, ID_EX_rd,
           IF_ID_rs1, IF_ID_rs2, IF_ID_uses_rs2, flush,
    output pc_write_en, IF_ID_write_en, ID_EX_write_en, ID_EX_bubble,
           EX_MEM_bubble, md_start, md_abort, md_result_sel, md_busy,
           stall_count
  );

endinterface

// File: rtl/muldiv_stall_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_stall_ctrl
// Purpose : hazard/stall controller for a 5-stage pipeline with a multi-cycle
//           M-extension unit. Holds the front of the pipeline while a
//           multiply or divide occupies EX, inserts a one-cycle bubble on a
//           load-use hazard, and cancels the M operation on a flush.
// Params  : MUL_LAT - stall cycles for multiplies   (1..63)
//           DIV_LAT - stall cycles for divide/rem   (1..63)
// Ports   : clk   - single clock, rising edge
//           rst_n - synchronous active-low reset
//           bus   - muldiv_stall_ctrl_if.slave (see interface file header)
// Timing  : an M instruction sits in EX for LAT+1 cycles: the request cycle
//           (IDLE, md_start), LAT-1 BUSY cycles, then one DONE cycle in which
//           the result is captured and the pipeline advances.
// -----------------------------------------------------------------------------
module muldiv_stall_ctrl #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  muldiv_stall_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // cnt holds the number of BUSY cycles still to run; the request cycle
  // itself is already one of the LAT stall cycles, hence the -1.
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic        md_req;
  logic        load_use;
  logic [5:0]  req_cnt;

  logic        pc_we;
  logic        if_id_we;
  logic        id_ex_we;
  logic        id_ex_bubble;
  logic        ex_mem_bubble;
  logic        md_start;
  logic        md_abort;
  logic        md_result_sel;
  logic        md_busy;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign md_req = bus.ID_EX_valid & (bus.ID_EX_is_mul | bus.ID_EX_is_div)
                & ~bus.flush;

  // x0 never carries a dependency; rs2 only matters when the ID instruction
  // actually reads it.
  assign load_use = bus.ID_EX_valid & bus.ID_EX_memread
                  & (bus.ID_EX_rd != 5'd0)
                  & ((bus.ID_EX_rd == bus.IF_ID_rs1)
                     | (bus.IF_ID_uses_rs2 & (bus.ID_EX_rd == bus.IF_ID_rs2)))
                  & ~bus.flush;

  // Divide wins when both decode flags are set.
  assign req_cnt = bus.ID_EX_is_div ? DIV_CNT : MUL_CNT;

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    md_start      = 1'b0;
    md_abort      = 1'b0;
    md_result_sel = 1'b0;
    md_busy       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (md_req) begin
          md_start      = 1'b1;
          md_busy       = 1'b1;
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_ex_we      = 1'b0;
          ex_mem_bubble = 1'b1;
          cnt_d         = req_cnt;
          // A single-cycle latency has no BUSY phase at all.
          state_d       = (req_cnt == 6'd0) ? DONE : BUSY;
        end else if (load_use) begin
          // Hold IF and ID for one cycle and let a NOP into EX.
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_ex_bubble  = 1'b1;
        end
      end

      BUSY: begin
        if (bus.flush) begin
          // The M instruction is being killed: cancel the unit and let the
          // redirected fetch proceed.
          md_abort      = 1'b1;
          state_d       = IDLE;
          cnt_d         = 6'd0;
        end else begin
          md_busy       = 1'b1;
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_ex_we      = 1'b0;
          ex_mem_bubble = 1'b1;
          if (cnt_q <= 6'd1) begin
            cnt_d       = 6'd0;
            state_d     = DONE;
          end else begin
            cnt_d       = cnt_q - 6'd1;
          end
        end
      end

      DONE: begin
        // Result lands in EX/MEM this cycle unless the instruction is killed.
        md_result_sel = ~bus.flush;
        cnt_d         = 6'd0;
        state_d       = IDLE;
      end

      default: begin
        cnt_d         = 6'd0;
        state_d       = IDLE;
      end
    endcase
  end

  // Count every cycle the PC is held, sticking at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_we && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 6'd0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign bus.pc_write_en    = pc_we;
  assign bus.IF_ID_write_en = if_id_we;
  assign bus.ID_EX_write_en = id_ex_we;
  assign bus.ID_EX_bubble   = id_ex_bubble;
  assign bus.EX_MEM_bubble  = ex_mem_bubble;
  assign bus.md_start       = md_start;
  assign bus.md_abort       = md_abort;
  assign bus.md_result_sel  = md_result_sel;
  assign bus.md_busy        = md_busy;
  assign bus.stall_count    = stall_count_q;

endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_stall_ctrl
// Directed bench for muldiv_stall_ctrl (MUL_LAT=2, DIV_LAT=32). Inputs change
// just after each falling edge; outputs are sampled 1 ns later, well away from
// the rising edge. Output vectors are packed as
// {pc_we, if_id_we, id_ex_we, id_ex_bubble, ex_mem_bubble,
//  md_start, md_abort, md_result_sel, md_busy}.
// -----------------------------------------------------------------------------
module tb_muldiv_stall_ctrl;

  localparam logic [8:0] V_NORM  = 9'b111_0_0_0_0_0_0;
  localparam logic [8:0] V_START = 9'b000_0_1_1_0_0_1;
  localparam logic [8:0] V_BUSY  = 9'b000_0_1_0_0_0_1;
  localparam logic [8:0] V_DONE  = 9'b111_0_0_0_0_1_0;
  localparam logic [8:0] V_LU    = 9'b001_1_0_0_0_0_0;
  localparam logic [8:0] V_ABORT = 9'b111_0_0_0_1_0_0;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_stall;

  muldiv_stall_ctrl_if bus ();

  muldiv_stall_ctrl #(
    .MUL_LAT(2),
    .DIV_LAT(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {bus.pc_write_en, bus.IF_ID_write_en, bus.ID_EX_write_en,
            bus.ID_EX_bubble, bus.EX_MEM_bubble, bus.md_start,
            bus.md_abort, bus.md_result_sel, bus.md_busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Check this cycle's outputs, advance the stall model, move to next cycle.
  task automatic step(input string tag, input logic [8:0] expv);
    #1;
    chk(tag, {23'd0, outs()}, {23'd0, expv});
    $display("cycle %s outs=%b stall_count=%0d", tag, outs(), bus.stall_count);
    if (!expv[8] && rst_n && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    @(negedge clk);
  endtask

  task automatic clear_in();
    bus.ID_EX_valid    = 1'b0;
    bus.ID_EX_is_mul   = 1'b0;
    bus.ID_EX_is_div   = 1'b0;
    bus.ID_EX_memread  = 1'b0;
    bus.ID_EX_rd       = 5'd0;
    bus.IF_ID_rs1      = 5'd0;
    bus.IF_ID_rs2      = 5'd0;
    bus.IF_ID_uses_rs2 = 1'b0;
    bus.flush          = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic uses2);
    clear_in();
    bus.ID_EX_valid    = 1'b1;
    bus.ID_EX_memread  = 1'b1;
    bus.ID_EX_rd       = rd;
    bus.IF_ID_rs1      = rs1;
    bus.IF_ID_rs2      = rs2;
    bus.IF_ID_uses_rs2 = uses2;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_stall = 32'd0;
    rst_n     = 1'b0;
    clear_in();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    step("reset_outs", V_NORM);
    chk("reset_stall_count", bus.stall_count, 32'd0);

    // MUL, latency 2: start@0, stall 0..1, result@2
    bus.ID_EX_valid = 1'b1; bus.ID_EX_is_mul = 1'b1;
    step("mul_c0_start", V_START);
    step("mul_c1_busy", V_BUSY);
    step("mul_c2_done", V_DONE);
    chk("mul_stall_count", bus.stall_count, 32'd2);
    clear_in();
    step("mul_after_idle", V_NORM);

    // DIV, latency 32, followed back-to-back by a MUL
    bus.ID_EX_valid = 1'b1; bus.ID_EX_is_div = 1'b1;
    step("div_c0_start", V_START);
    for (int i = 1; i < 32; i++) step($sformatf("div_c%0d_busy", i), V_BUSY);
    step("div_c32_done", V_DONE);
    chk("div_stall_count", bus.stall_count, 32'd34);
    bus.ID_EX_is_div = 1'b0; bus.ID_EX_is_mul = 1'b1;
    step("mul_c33_start", V_START);
    step("mul_c34_busy", V_BUSY);
    step("mul_c35_done", V_DONE);
    clear_in();
    step("idle_after_mul", V_NORM);
    chk("stall_count_36", bus.stall_count, 32'd36);

    // Both flags set: divide latency wins. Flush at cnt=10 (cycle 22).
    bus.ID_EX_valid = 1'b1; bus.ID_EX_is_mul = 1'b1; bus.ID_EX_is_div = 1'b1;
    step("both_c0_start", V_START);
    for (int i = 1; i < 22; i++) step($sformatf("both_c%0d_busy", i), V_BUSY);
    bus.flush = 1'b1;
    step("flush_busy_abort", V_ABORT);
    clear_in();
    step("after_abort_idle", V_NORM);
    chk("stall_count_abort", bus.stall_count, 32'd58);

    // Flush in IDLE suppresses md_start
    bus.ID_EX_valid = 1'b1; bus.ID_EX_is_mul = 1'b1; bus.flush = 1'b1;
    step("flush_idle_no_start", V_NORM);
    // Flush in DONE drops the result
    bus.flush = 1'b0;
    step("mul2_start", V_START);
    step("mul2_busy", V_BUSY);
    bus.flush = 1'b1;
    step("flush_done_no_result", V_NORM);
    clear_in();
    step("after_flush_done", V_NORM);

    // Load-use hazards
    load(5'd5, 5'd5, 5'd1, 1'b1);
    step("lu_rs1_match", V_LU);
    clear_in();
    step("lu_bubble_passed", V_NORM);
    load(5'd5, 5'd6, 5'd5, 1'b1);
    step("lu_rs2_match", V_LU);
    load(5'd5, 5'd6, 5'd5, 1'b0);
    step("lu_rs2_unused", V_NORM);
    load(5'd0, 5'd0, 5'd0, 1'b1);
    step("lu_rd_zero", V_NORM);
    load(5'd7, 5'd7, 5'd0, 1'b0);
    bus.flush = 1'b1;
    step("lu_flushed", V_NORM);
    // M hold beats load-use; load-use is not evaluated in DONE
    load(5'd9, 5'd9, 5'd0, 1'b0);
    bus.ID_EX_is_mul = 1'b1;
    step("md_over_lu_start", V_START);
    step("md_over_lu_busy", V_BUSY);
    step("md_over_lu_done", V_DONE);
    clear_in();
    step("md_over_lu_idle", V_NORM);
    chk("stall_count_model", bus.stall_count, exp_stall);

    // Reset in the middle of a DIV
    bus.ID_EX_valid = 1'b1; bus.ID_EX_is_div = 1'b1;
    step("rdiv_c0_start", V_START);
    for (int i = 1; i < 5; i++) step($sformatf("rdiv_c%0d_busy", i), V_BUSY);
    clear_in();
    rst_n = 1'b0;
    step("rdiv_reset_no_abort", V_BUSY);
    rst_n = 1'b1;
    exp_stall = 32'd0;
    step("rdiv_after_reset", V_NORM);
    chk("rdiv_stall_count", bus.stall_count, 32'd0);

    // Saturation of stall_count
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    bus.ID_EX_valid = 1'b1; bus.ID_EX_is_mul = 1'b1;
    step("sat_start", V_START);
    chk("sat_reach_max", bus.stall_count, 32'hFFFF_FFFF);
    step("sat_busy", V_BUSY);
    chk("sat_hold_max", bus.stall_count, 32'hFFFF_FFFF);
    step("sat_done", V_DONE);
    chk("sat_hold_after_done", bus.stall_count, 32'hFFFF_FFFF);
    clear_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_stall_ctrl.md
MULDIV_STALL_CTRL -- requirements
Module: muldiv_stall_ctrl

Interface
REQ-001 Parameter: MUL_LAT, 2, stall cycles for MUL/MULH/MULHSU/MULHU; legal range 1..63.
REQ-002 Parameter: DIV_LAT, 32, stall cycles for DIV/DIVU/REM/REMU; legal range 1..63.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ID_EX_valid  in  1  EX stage holds a real instruction, not a bubble.
REQ-006 ID_EX_is_mul / ID_EX_is_div  in  1 each  EX instruction is an M-extension multiply / divide-remainder.
REQ-007 ID_EX_memread  in  1  EX instruction is a load.
REQ-008 ID_EX_rd  in  5  EX destination register.
REQ-009 IF_ID_rs1, IF_ID_rs2  in  5 each  ID source registers.
REQ-010 IF_ID_uses_rs2  in  1  ID instruction reads rs2.
REQ-011 flush  in  1  taken branch/jump kills IF, ID and EX contents.
REQ-012 pc_write_en, IF_ID_write_en, ID_EX_write_en  out  1 each  pipeline register enables; 0 holds.
REQ-013 ID_EX_bubble  out  1  load ID/EX with a NOP.
REQ-014 EX_MEM_bubble  out  1  load EX/MEM with a NOP.
REQ-015 md_start  out  1  one-cycle start pulse to the M unit.
REQ-016 md_abort  out  1  one-cycle cancel pulse to the M unit.
REQ-017 md_result_sel  out  1  EX/MEM captures the M-unit result this cycle.
REQ-018 md_busy  out  1  M operation in progress.
REQ-019 stall_count  out  32  saturating count of cycles with pc_write_en=0.

Function
REQ-020 FSM states: IDLE, BUSY, DONE; 6-bit down-counter cnt.
REQ-021 md_req = ID_EX_valid & (ID_EX_is_mul | ID_EX_is_div) & ~flush.
REQ-022 IDLE & md_req: md_start=1 combinationally; next BUSY; cnt <= (is_div ? DIV_LAT : MUL_LAT) - 1; is_div takes priority if both set.
REQ-023 BUSY: cnt decrements each cycle; cnt==0 -> DONE.
REQ-024 IDLE (request cycle) and BUSY: pc_write_en=IF_ID_write_en=ID_EX_write_en=0, EX_MEM_bubble=1, md_busy=1.
REQ-025 DONE: md_result_sel=1, all write enables 1, EX_MEM_bubble=0, md_busy=0; next IDLE unconditionally; md_start never issued in DONE.
REQ-026 Total: M instruction occupies EX for LAT+1 cycles; exactly LAT stall cycles.
REQ-027 Load-use: ID_EX_valid & ID_EX_memread & ID_EX_rd!=0 & (ID_EX_rd==IF_ID_rs1 | (IF_ID_uses_rs2 & ID_EX_rd==IF_ID_rs2)) -> pc_write_en=0, IF_ID_write_en=0, ID_EX_bubble=1, ID_EX_write_en=1; one cycle; evaluated only in IDLE with md_req=0.
REQ-028 flush in BUSY or DONE: md_abort=1 (BUSY only), next state IDLE, cnt<=0, md_result_sel=0, enables 1; flush in IDLE suppresses md_start and load-use stall.
REQ-029 flush has priority over md_req and load-use; md hold has priority over load-use.
REQ-030 stall_count increments when pc_write_en=0, saturates at 32'hFFFFFFFF.
REQ-031 Outputs not listed as asserted in a state are 0 (enables: 1).

Reset
REQ-032 rst_n=0 at a rising edge: state<=IDLE, cnt<=0, stall_count<=0, regardless of state, including mid-BUSY; no md_abort pulse on reset.
REQ-033 Reset-state outputs with no request pending: enables 1, all other outputs 0.

Verification
REQ-034 MUL in EX, MUL_LAT=2, cycle 0 -> md_start@0; enables 0 @0..1; md_result_sel@2; stall_count=2.
REQ-035 DIV in EX, DIV_LAT=32 -> stall 32 cycles, md_result_sel@32, next MUL in EX starts @33 with no idle gap.
REQ-036 LW x5 in EX, ID ADD x6,x5,x1 -> one cycle pc_write_en=0, ID_EX_bubble=1; ID_EX_rd=0 or rs2 unused match -> no stall.
REQ-037 DIV BUSY at cnt=10, flush=1 -> md_abort one cycle, IDLE next, enables 1, no md_result_sel.
REQ-038 rst_n=0 mid-DIV -> IDLE, stall_count=0 next cycle, no md_abort, no md_start.
REQ-039 Preload stall_count near max via long stall run (force) -> holds at 32'hFFFFFFFF.
